// File: rtl/piezo_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the piezo transformer drive: loop FSM encoding,
// VCO increment words and phase-lock loop constants.
package piezo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // INC_START is the driver's fixed 80 kHz word.
    localparam logic [14:0] INC_START  = 15'd26844;
    localparam logic [14:0] INC_MAX    = 15'd30000;
    localparam logic [14:0] INC_MIN    = 15'd23000;
    localparam logic [14:0] SWEEP_STEP = 15'd16;
    localparam logic [1:0]  SETTLE     = 2'd2;
    localparam int          KI_SHIFT   = 3;
    localparam logic [9:0]  LOCK_TOL   = 10'd4;
    localparam logic [4:0]  LOCK_CNT   = 5'd16;
    localparam logic [9:0]  UNLOCK_TOL = 10'd32;
    localparam logic [3:0]  UNLOCK_CNT = 4'd8;
    localparam logic [3:0]  SAT_LIMIT  = 4'd8;

    // Magnitude needs 10 bits so that -256 does not overflow.
    function automatic logic [9:0] phase_abs(input logic signed [8:0] p);
        logic signed [9:0] w;
        w = {p[8], p};
        return w[9] ? 10'(-w) : 10'(w);
    endfunction

endpackage

// File: rtl/lock_detector.sv
`timescale 1ns/1ps
// Lock qualifier: counts consecutive in-tolerance samples to declare lock and
// consecutive out-of-tolerance samples to drop it.
module lock_detector
    import piezo_pkg::*;
(
    input  logic              clk12d5MHz,
    input  logic              rst,
    input  logic              strobe_i,
    input  logic signed [8:0] phase_i,
    input  state_t            mode_i,
    input  logic              clear_i,
    output logic              lock_set_o,
    output logic              lock_clr_o,
    output logic              locked_o
);

    logic [9:0] mag;
    logic       in_tol;
    logic       out_tol;
    logic [4:0] in_cnt_q, in_cnt_d;
    logic [3:0] out_cnt_q, out_cnt_d;
    logic       locked_q, locked_d;

    assign mag     = phase_abs(phase_i);
    assign in_tol  = (mag <= LOCK_TOL);
    assign out_tol = (mag > UNLOCK_TOL);

    always_comb begin
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        locked_d   = locked_q;
        lock_set_o = 1'b0;
        lock_clr_o = 1'b0;
        if (clear_i) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            locked_d  = 1'b0;
        end else if (strobe_i) begin
            if (mode_i == ST_LOCKED) begin
                if (!out_tol)
                    out_cnt_d = '0;
                else if (out_cnt_q != UNLOCK_CNT)
                    out_cnt_d = out_cnt_q + 4'd1;
                if (out_cnt_d == UNLOCK_CNT) begin
                    lock_clr_o = 1'b1;
                    locked_d   = 1'b0;
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                end
            end else begin
                if (!in_tol)
                    in_cnt_d = '0;
                else if (in_cnt_q != LOCK_CNT)
                    in_cnt_d = in_cnt_q + 5'd1;
                if (in_cnt_d == LOCK_CNT) begin
                    lock_set_o = 1'b1;
                    locked_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk12d5MHz or posedge rst) begin
        if (rst) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            locked_q  <= locked_d;
        end
    end

    assign locked_o = locked_q;

endmodule

// File: rtl/phase_lock_controller.sv
`timescale 1ns/1ps
// Closed-loop VCO frequency controller: sweeps down to resonance, then tracks
// it with a saturating integral loop and reports lock.
module phase_lock_controller
    import piezo_pkg::*;
(
    input  logic              clk12d5MHz,
    input  logic              rst,
    input  logic              enable,
    input  logic              phase_valid,
    input  logic signed [8:0] phase,
    output logic [14:0]       increment,
    output logic              locked,
    output logic              sweeping,
    output logic              fault
);

    state_t             state_q;
    logic [14:0]        inc_q;
    logic [1:0]         settle_q;
    logic [3:0]         sat_q, sat_d;
    logic               sweeping_q;
    logic               fault_q;
    logic signed [16:0] sum_d;
    logic [14:0]        inc_clamp_d;
    logic               clamped_d;
    logic               tracking;
    logic               resweep;
    logic               ld_clear;
    logic               ld_strobe;
    logic               lock_set;
    logic               lock_clr;

    function automatic logic is_clamped(input logic signed [16:0] s);
        return (s < $signed({2'b00, INC_MIN})) || (s > $signed({2'b00, INC_MAX}));
    endfunction

    function automatic logic [14:0] clamp_inc(input logic signed [16:0] s);
        if (s < $signed({2'b00, INC_MIN}))
            return INC_MIN;
        if (s > $signed({2'b00, INC_MAX}))
            return INC_MAX;
        return s[14:0];
    endfunction

    // Arithmetic shift of the sign-extended phase floors toward -inf.
    always_comb begin
        sum_d       = $signed({2'b00, inc_q}) - ($signed({{8{phase[8]}}, phase}) >>> KI_SHIFT);
        clamped_d   = is_clamped(sum_d);
        inc_clamp_d = clamp_inc(sum_d);
        sat_d       = '0;
        if (clamped_d)
            sat_d = (sat_q == SAT_LIMIT) ? sat_q : sat_q + 4'd1;
    end

    assign tracking  = (state_q == ST_TRACK) || (state_q == ST_LOCKED);
    assign resweep   = enable && tracking && phase_valid && (sat_d == SAT_LIMIT);
    assign ld_clear  = !enable || !tracking || resweep;
    assign ld_strobe = phase_valid && tracking;

    lock_detector u_lock_detector (
        .clk12d5MHz (clk12d5MHz),
        .rst        (rst),
        .strobe_i   (ld_strobe),
        .phase_i    (phase),
        .mode_i     (state_q),
        .clear_i    (ld_clear),
        .lock_set_o (lock_set),
        .lock_clr_o (lock_clr),
        .locked_o   (locked)
    );

    always_ff @(posedge clk12d5MHz or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            inc_q      <= INC_START;
            settle_q   <= '0;
            sat_q      <= '0;
            sweeping_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            if (!enable) begin
                state_q    <= ST_IDLE;
                inc_q      <= INC_START;
                settle_q   <= '0;
                sat_q      <= '0;
                sweeping_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q    <= ST_SWEEP;
                        inc_q      <= INC_MAX;
                        settle_q   <= SETTLE;
                        sweeping_q <= 1'b1;
                    end
                    ST_SWEEP: begin
                        if (phase_valid) begin
                            if (settle_q != 2'd0) begin
                                settle_q <= settle_q - 2'd1;
                            end else if (phase > 9'sd0) begin
                                settle_q <= SETTLE;
                                if (inc_q < INC_MIN + SWEEP_STEP) begin
                                    inc_q   <= INC_MAX;
                                    fault_q <= 1'b1;
                                end else begin
                                    inc_q <= inc_q - SWEEP_STEP;
                                end
                            end else begin
                                state_q    <= ST_TRACK;
                                settle_q   <= '0;
                                sat_q      <= '0;
                                sweeping_q <= 1'b0;
                            end
                        end
                    end
                    ST_TRACK, ST_LOCKED: begin
                        if (phase_valid) begin
                            if (resweep) begin
                                state_q    <= ST_SWEEP;
                                inc_q      <= INC_MAX;
                                settle_q   <= SETTLE;
                                sat_q      <= '0;
                                sweeping_q <= 1'b1;
                            end else begin
                                inc_q <= inc_clamp_d;
                                sat_q <= sat_d;
                                if (state_q == ST_TRACK && lock_set)
                                    state_q <= ST_LOCKED;
                                else if (state_q == ST_LOCKED && lock_clr)
                                    state_q <= ST_TRACK;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign increment = inc_q;
    assign sweeping  = sweeping_q;
    assign fault     = fault_q;

endmodule
